// File: rtl/led_reg_pkg.sv
// Shared definitions for the LED register bank: mode encoding and helpers.
package led_reg_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_LOAD = 2'b00;
    localparam mode_t MODE_INC  = 2'b01;
    localparam mode_t MODE_DEC  = 2'b10;
    localparam mode_t MODE_SHL  = 2'b11;

    // Width of a down-counter able to hold the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/led_act_stretch.sv
// Retriggerable pulse stretcher: trig_i reloads STRETCH, led_o stays high while nonzero.
module led_act_stretch
    import led_reg_pkg::*;
#(
    parameter int STRETCH = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic trig_i,
    output logic led_o
);

    localparam int CW = cnt_width(STRETCH);
    localparam logic [CW-1:0] LOAD_VAL = CW'(STRETCH);

    logic [CW-1:0] cnt;

    // Retrigger overwrites rather than adds, so holding time never accumulates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (trig_i)
            cnt <= LOAD_VAL;
        else if (cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign led_o = (cnt != '0);

endmodule

// File: rtl/led_reg_bank.sv
// Loadable/counting/shifting register with wrap pulse, per-bit LEDs and a stretched activity LED.
module led_reg_bank
    import led_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STRETCH = 15,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             wrap_o,
    output logic [WIDTH-1:0] led_o,
    output logic             act_led_o
);

    mode_t            mode;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_inc;
    logic [WIDTH-1:0] q_dec;
    logic [WIDTH-1:0] q_shl;
    logic [WIDTH-1:0] q_op;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_q;
    logic             wrap_nxt;
    logic             changed;

    assign mode  = mode_t'(mode_i);
    assign q_inc = q + WIDTH'(1);
    assign q_dec = q - WIDTH'(1);

    generate
        if (WIDTH == 1) begin : g_shl_1
            assign q_shl = d_i[0];
        end else begin : g_shl_n
            assign q_shl = {q[WIDTH-2:0], d_i[0]};
        end
    endgenerate

    always_comb begin
        q_op = q;
        case (mode)
            MODE_LOAD: q_op = d_i;
            MODE_INC:  q_op = q_inc;
            MODE_DEC:  q_op = q_dec;
            MODE_SHL:  q_op = q_shl;
            default:   q_op = q;
        endcase
    end

    assign q_nxt    = en_i ? q_op : q;
    assign wrap_nxt = en_i && (((mode == MODE_INC) && (&q)) ||
                               ((mode == MODE_DEC) && (~|q)));
    // Activity is judged on the value, so no-op loads/shifts stay dark.
    assign changed  = (q_nxt != q);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q      <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            q      <= q_nxt;
            wrap_q <= wrap_nxt;
        end
    end

    led_act_stretch #(
        .STRETCH (STRETCH)
    ) u_act (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .trig_i (changed),
        .led_o  (act_led_o)
    );

    assign q_o    = q;
    assign led_o  = q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_led_reg_bank.sv
// Scoreboard bench for led_reg_bank (WIDTH=8, STRETCH=15).
module tb_led_reg_bank;
    import led_reg_pkg::*;

    localparam int STRETCH = 15;

    typedef struct {
        logic [7:0] q;
        logic       wrap;
        logic       act;
    } exp_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic [1:0] mode_i = 2'b00;
    logic [7:0] d_i = 8'h00;
    logic [7:0] q_o;
    logic       wrap_o;
    logic [7:0] led_o;
    logic       act_led_o;

    exp_t       sb[$];
    logic [7:0] m_q;
    int         m_cnt;
    int         n_cmp = 0;
    int         n_err = 0;

    led_reg_bank #(.WIDTH(8), .STRETCH(STRETCH), .RESET_VAL(8'h00)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .en_i      (en_i),
        .mode_i    (mode_i),
        .d_i       (d_i),
        .q_o       (q_o),
        .wrap_o    (wrap_o),
        .led_o     (led_o),
        .act_led_o (act_led_o)
    );

    always #5 clk_i = ~clk_i;

    // Drive one operation, push the reference result, then clock it in.
    task automatic op(input logic en, input logic [1:0] mode, input logic [7:0] d);
        logic [7:0] nq;
        logic       w;
        exp_t       e;
        @(negedge clk_i);
        en_i = en; mode_i = mode; d_i = d;
        nq = m_q;
        w  = 1'b0;
        if (en) begin
            case (mode)
                2'b00: nq = d;
                2'b01: begin nq = m_q + 8'd1; w = (m_q == 8'hFF); end
                2'b10: begin nq = m_q - 8'd1; w = (m_q == 8'h00); end
                default: nq = {m_q[6:0], d[0]};
            endcase
        end
        if (nq != m_q) m_cnt = STRETCH;
        else if (m_cnt > 0) m_cnt = m_cnt - 1;
        m_q = nq;
        e.q = m_q; e.wrap = w; e.act = (m_cnt != 0);
        sb.push_back(e);
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++; if (q_o !== 8'h00) begin n_err++; $display("FAIL reset q: got %h want 00", q_o); end
        n_cmp++; if (led_o !== 8'h00) begin n_err++; $display("FAIL reset led: got %h want 00", led_o); end
        n_cmp++; if (wrap_o !== 1'b0) begin n_err++; $display("FAIL reset wrap: got %b want 0", wrap_o); end
        n_cmp++; if (act_led_o !== 1'b0) begin n_err++; $display("FAIL reset act: got %b want 0", act_led_o); end
        m_q = 8'h00; m_cnt = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_t e;
            op(1'b0, MODE_INC, 8'h00);
            e = sb.pop_front();
            n_cmp++; if (wrap_o !== e.wrap || act_led_o !== e.act || q_o !== e.q) begin
                n_err++; $display("FAIL reset_release: got q=%h w=%b a=%b want q=%h w=%b a=%b",
                                  q_o, wrap_o, act_led_o, e.q, e.wrap, e.act);
            end
        end
    endtask

    task automatic test_load();
        exp_t e;
        int   hi;
        op(1'b1, MODE_LOAD, 8'hA5);
        e = sb.pop_front();
        n_cmp++; if (q_o !== 8'hA5) begin n_err++; $display("FAIL load q: got %h want a5", q_o); end
        n_cmp++; if (led_o !== 8'hA5) begin n_err++; $display("FAIL load led: got %h want a5", led_o); end
        n_cmp++; if (act_led_o !== e.act) begin n_err++; $display("FAIL load act0: got %b want %b", act_led_o, e.act); end
        hi = act_led_o ? 1 : 0;
        for (int i = 0; i < STRETCH + 2; i++) begin
            op(1'b0, MODE_LOAD, 8'h00);
            e = sb.pop_front();
            if (act_led_o === 1'b1) hi++;
            n_cmp++; if (act_led_o !== e.act || q_o !== e.q) begin
                n_err++; $display("FAIL load stretch[%0d]: got q=%h a=%b want q=%h a=%b", i, q_o, act_led_o, e.q, e.act);
            end
        end
        n_cmp++; if (hi != STRETCH) begin n_err++; $display("FAIL load act_len: got %0d want %0d", hi, STRETCH); end
    endtask

    task automatic test_inc_wrap();
        logic [7:0] want_q[3] = '{8'hFF, 8'h00, 8'h01};
        logic       want_w[3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            exp_t e;
            op(1'b1, (i == 0) ? MODE_LOAD : MODE_INC, 8'hFF);
            e = sb.pop_front();
            n_cmp++; if (q_o !== want_q[i] || q_o !== e.q) begin n_err++; $display("FAIL inc q[%0d]: got %h want %h", i, q_o, want_q[i]); end
            n_cmp++; if (wrap_o !== want_w[i]) begin n_err++; $display("FAIL inc wrap[%0d]: got %b want %b", i, wrap_o, want_w[i]); end
        end
    endtask

    task automatic test_dec_hold();
        exp_t e;
        op(1'b1, MODE_LOAD, 8'h00);
        e = sb.pop_front();
        n_cmp++; if (q_o !== 8'h00) begin n_err++; $display("FAIL dec pre q: got %h want 00", q_o); end
        op(1'b1, MODE_DEC, 8'h00);
        e = sb.pop_front();
        n_cmp++; if (q_o !== 8'hFF) begin n_err++; $display("FAIL dec q: got %h want ff", q_o); end
        n_cmp++; if (wrap_o !== 1'b1) begin n_err++; $display("FAIL dec wrap: got %b want 1", wrap_o); end
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 2'(i), 8'(i * 37));
            e = sb.pop_front();
            n_cmp++; if (q_o !== 8'hFF || wrap_o !== 1'b0 || act_led_o !== e.act) begin
                n_err++; $display("FAIL hold[%0d]: got q=%h w=%b a=%b want q=ff w=0 a=%b", i, q_o, wrap_o, act_led_o, e.act);
            end
        end
    endtask

    task automatic test_shl();
        logic [7:0] want_q[3] = '{8'h03, 8'h07, 8'h0F};
        exp_t e;
        op(1'b1, MODE_LOAD, 8'h81);
        e = sb.pop_front();
        for (int i = 0; i < 3; i++) begin
            op(1'b1, MODE_SHL, 8'hFF);
            e = sb.pop_front();
            n_cmp++; if (q_o !== want_q[i] || wrap_o !== 1'b0) begin
                n_err++; $display("FAIL shl[%0d]: got q=%h w=%b want q=%h w=0", i, q_o, wrap_o, want_q[i]);
            end
        end
    endtask

    // Change, change two cycles later, equal-value load mid-stretch, then idle.
    task automatic test_retrigger();
        exp_t e;
        int   hi;
        for (int i = 0; i < STRETCH + 1; i++) begin op(1'b0, MODE_LOAD, 8'h00); e = sb.pop_front(); end
        n_cmp++; if (act_led_o !== 1'b0) begin n_err++; $display("FAIL retrig idle act: got %b want 0", act_led_o); end
        op(1'b1, MODE_LOAD, 8'h10); e = sb.pop_front();
        op(1'b0, MODE_LOAD, 8'h00); e = sb.pop_front();
        op(1'b1, MODE_LOAD, 8'h20); e = sb.pop_front();
        hi = 1;
        op(1'b0, MODE_LOAD, 8'h00); e = sb.pop_front(); hi += act_led_o ? 1 : 0;
        op(1'b1, MODE_LOAD, 8'h20); e = sb.pop_front(); hi += act_led_o ? 1 : 0;
        for (int i = 0; i < STRETCH; i++) begin
            op(1'b0, MODE_LOAD, 8'h00);
            e = sb.pop_front();
            if (act_led_o === 1'b1) hi++;
            n_cmp++; if (act_led_o !== e.act) begin n_err++; $display("FAIL retrig act[%0d]: got %b want %b", i, act_led_o, e.act); end
        end
        n_cmp++; if (hi != STRETCH) begin n_err++; $display("FAIL retrig act_len: got %0d want %0d", hi, STRETCH); end
    endtask

    task automatic test_no_change();
        exp_t e;
        op(1'b1, MODE_LOAD, 8'hFF); e = sb.pop_front();
        for (int i = 0; i < STRETCH + 1; i++) begin op(1'b0, MODE_LOAD, 8'h00); e = sb.pop_front(); end
        op(1'b1, MODE_LOAD, 8'hFF); e = sb.pop_front();
        n_cmp++; if (act_led_o !== 1'b0) begin n_err++; $display("FAIL eq_load act: got %b want 0", act_led_o); end
        op(1'b1, MODE_SHL, 8'h01); e = sb.pop_front();
        n_cmp++; if (act_led_o !== 1'b0 || q_o !== 8'hFF) begin
            n_err++; $display("FAIL eq_shl: got q=%h a=%b want q=ff a=0", q_o, act_led_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] seq[4] = '{MODE_INC, MODE_DEC, MODE_INC, MODE_DEC};
        exp_t e;
        op(1'b1, MODE_LOAD, 8'hFF); e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            op(1'b1, seq[i], 8'h00);
            e = sb.pop_front();
            n_cmp++; if (wrap_o !== 1'b1 || q_o !== e.q) begin
                n_err++; $display("FAIL b2b[%0d]: got q=%h w=%b want q=%h w=1", i, q_o, wrap_o, e.q);
            end
        end
    endtask

    task automatic test_reset_midflight();
        exp_t e;
        op(1'b1, MODE_LOAD, 8'hFE); e = sb.pop_front();
        op(1'b1, MODE_INC, 8'h00); e = sb.pop_front();
        #2 rst_i = 1'b1;
        #1;
        m_q = 8'h00; m_cnt = 0;
        n_cmp++; if (q_o !== 8'h00 || act_led_o !== 1'b0 || led_o !== 8'h00) begin
            n_err++; $display("FAIL rst_mid: got q=%h a=%b led=%h want 00/0/00", q_o, act_led_o, led_o);
        end
        @(negedge clk_i);
        en_i = 1'b0;
        #2 rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            op(1'b0, MODE_INC, 8'h00);
            e = sb.pop_front();
            n_cmp++; if (wrap_o !== 1'b0 || act_led_o !== 1'b0 || q_o !== 8'h00) begin
                n_err++; $display("FAIL rst_release[%0d]: got q=%h w=%b a=%b want 00/0/0", i, q_o, wrap_o, act_led_o);
            end
        end
        op(1'b1, MODE_INC, 8'h00); e = sb.pop_front();
        n_cmp++; if (q_o !== 8'h01 || wrap_o !== 1'b0 || act_led_o !== 1'b1) begin
            n_err++; $display("FAIL rst_first_op: got q=%h w=%b a=%b want 01/0/1", q_o, wrap_o, act_led_o);
        end
    endtask

    task automatic test_random();
        exp_t e;
        for (int i = 0; i < 300; i++) begin
            op(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
            e = sb.pop_front();
            n_cmp++; if (q_o !== e.q || led_o !== e.q || wrap_o !== e.wrap || act_led_o !== e.act) begin
                n_err++; $display("FAIL rand[%0d]: got q=%h led=%h w=%b a=%b want q=%h w=%b a=%b",
                                  i, q_o, led_o, wrap_o, act_led_o, e.q, e.wrap, e.act);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_inc_wrap();
        test_dec_hold();
        test_shl();
        test_retrigger();
        test_no_change();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
